regfile_preloader: RTL and testbench

- Debug/test block that loads the mips_core register file from an external 32-bit word stream. It is the write-side counterpart of the end-of-run register dump.
- Accepts a header word plus N data words over a valid/ready handshake.
- Stalls the core through a req/ack pair, then issues one register-file write per accepted data word.
- Sits between the bench/debug host and the REGISTER_FILE write port; its write port is muxed ahead of the core's writeback.

---
 rtl/mips_dbg_pkg.sv | 33 +++
 rtl/up_counter.sv | 25 ++
 rtl/regfile_preloader.sv | 134 +++++++++++++
 tb/tb_regfile_preloader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the mips_core debug blocks: FSM encoding, header
// field layout and register-file geometry.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        LOAD     = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 6;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    localparam int HDR_MAGIC_MSB = 31;
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_COUNT_MSB = 10;
    localparam int HDR_COUNT_LSB = 5;
    localparam int HDR_START_MSB = 4;
    localparam int HDR_START_LSB = 0;

    // A header is usable only with the right magic and a count of 1..REG_COUNT.
    function automatic logic header_ok(input logic [31:0] word, input logic [7:0] magic);
        logic [CNT_W-1:0] cnt;
        cnt = word[HDR_COUNT_MSB:HDR_COUNT_LSB];
        return (word[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == magic) &&
               (cnt != '0) && (cnt <= CNT_W'(REG_COUNT));
    endfunction

endpackage

// File: rtl/up_counter.sv
// Generic saturating up-counter with synchronous clear.
module up_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != MAX)) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_preloader.sv
// Loads the mips_core register file from a header + data word stream while
// the core is held in a stall; write-side twin of the register dump.
module regfile_preloader
    import mips_dbg_pkg::*;
#(
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_data,
    output logic                  stall_req,
    input  logic                  stall_ack,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      remain_q, remain_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [31:0]           rf_wdata_q, rf_wdata_d;
    logic                  err_q, err_d;
    logic                  live_q;
    logic [TW-1:0]         timer;
    logic                  hs;

    up_counter #(
        .WIDTH (TW),
        .MAX   (TW'(ACK_TIMEOUT))
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q != WAIT_ACK),
        .en_i    (state_q == WAIT_ACK),
        .count_o (timer)
    );

    // live_q keeps s_ready low on the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
            live_q     <= 1'b1;
        end
    end

    assign s_ready = live_q && ((state_q == IDLE) || (state_q == LOAD));
    assign hs      = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (header_ok(s_data, MAGIC)) begin
                        addr_d   = s_data[HDR_START_MSB:HDR_START_LSB];
                        remain_d = s_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
                        state_d  = WAIT_ACK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                if (stall_ack) begin
                    state_d = LOAD;
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            LOAD: begin
                if (hs) begin
                    // r0 is hardwired zero: the word is consumed but never written.
                    if (addr_q != '0) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = addr_q;
                        rf_wdata_d = s_data;
                    end
                    addr_d   = addr_q + 5'd1;
                    remain_d = remain_q - 6'd1;
                    if (remain_q == 6'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall_req = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_regfile_preloader.sv
// Directed + randomized bench for regfile_preloader with a transaction-level
// model of which registers a load must write.
module tb_regfile_preloader;

    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        stall_req;
    logic        stall_ack = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] obs_q[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          hs_cnt   = 0;

    int ack_en  = 1;
    int ack_dly = 3;
    int req_cyc = 0;

    regfile_preloader #(.MAGIC(8'hA5), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .stall_req (stall_req),
        .stall_ack (stall_ack),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (rf_we) obs_q.push_back({rf_waddr, rf_wdata});
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (s_valid && s_ready && !rst) hs_cnt++;
    end

    // Core model: freezes ack_dly cycles after stall_req rises.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_req && ack_en != 0) begin
                if (req_cyc >= ack_dly) stall_ack = 1'b1;
                req_cyc++;
            end else begin
                stall_ack = 1'b0;
                req_cyc   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] magic, input int cnt, input int start);
        logic [5:0] c;
        logic [4:0] s;
        c = cnt[5:0];
        s = start[4:0];
        return {magic, 13'd0, c, s};
    endfunction

    // Returns after the handshake edge, at edge+1.
    task automatic send_word(input logic [31:0] d);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (waited >= 200) chk("ready_timeout", 64'(waited), 64'd0);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic clear_mon();
        obs_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        hs_cnt   = 0;
    endtask

    task automatic run_load(input int start, input int cnt, input int gap_max,
                            input bit idx_data, input string tag);
        logic [31:0] data[32];
        logic [36:0] exp_q[$];
        int          last_a;
        for (int k = 0; k < 32; k++) data[k] = idx_data ? 32'(k) : $urandom;
        for (int k = 0; k < cnt; k++) begin
            int a;
            a = (start + k) % 32;
            if (a != 0) exp_q.push_back({a[4:0], data[k]});
        end
        last_a = (start + cnt - 1) % 32;
        clear_mon();
        send_word(hdr(8'hA5, cnt, start));
        for (int k = 0; k < cnt; k++) begin
            int gap;
            gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            if (k > 0) for (int g = 0; g < gap; g++) tick();
            send_word(data[k]);
        end
        chk({tag, "_done_pulse"}, 64'(done), 64'd1);
        chk({tag, "_last_we"}, 64'(rf_we), (last_a != 0) ? 64'd1 : 64'd0);
        chk({tag, "_req_in_done"}, 64'(stall_req), 64'd1);
        tick();
        chk({tag, "_req_fall"}, 64'({stall_req, busy, done}), 64'd0);
        tick();
        chk({tag, "_hs_cnt"}, 64'(hs_cnt), 64'(cnt + 1));
        chk({tag, "_wr_cnt"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        $display("load %s start=%0d count=%0d writes=%0d", tag, start, cnt, obs_q.size());
    endtask

    task automatic bad_header(input logic [31:0] w, input string tag);
        clear_mon();
        send_word(w);
        chk({tag, "_err"}, 64'({err, stall_req, busy}), 64'b100);
        tick();
        chk({tag, "_idle"}, 64'({err, stall_req, busy, s_ready}), 64'b0001);
        $display("bad header %s word=%h", tag, w);
    endtask

    initial begin
        int waited;
        logic [31:0] d1, d2;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("reset_outs", 64'({s_ready, stall_req, rf_we, rf_waddr, rf_wdata, busy, done, err}), 64'd0);
        tick();
        chk("ready_after_reset", 64'(s_ready), 64'd1);

        // Load four registers, ack after 3 cycles
        ack_en = 1; ack_dly = 3;
        run_load(5, 4, 0, 1'b0, "four");
        // Wrap through r31 -> r0 (skipped) -> r1
        run_load(30, 4, 0, 1'b0, "wrap");

        // Bad headers
        bad_header(hdr(8'h5A, 4, 1), "magic");
        bad_header(hdr(8'hA5, 0, 1), "count0");
        bad_header(hdr(8'hA5, 33, 1), "count33");

        // Ack timeout
        ack_en = 0;
        clear_mon();
        send_word(hdr(8'hA5, 2, 3));
        chk("to_req_rise", 64'(stall_req), 64'd1);
        waited = 0;
        while (!err && waited < 100) begin
            tick();
            waited++;
            if (!err) chk("to_req_held", 64'(stall_req), 64'd1);
        end
        chk("to_latency", 64'(waited), 64'(ACK_TIMEOUT));
        chk("to_req_drop", 64'({stall_req, busy}), 64'd0);
        send_word(32'h0000_0011);
        chk("to_next_is_header", 64'({err, stall_req}), 64'b10);
        tick();
        chk("to_hs_cnt", 64'(hs_cnt), 64'd2);
        chk("to_wr_cnt", 64'(obs_q.size()), 64'd0);
        $display("ack timeout after %0d cycles", waited);
        ack_en = 1; ack_dly = 1;

        // Backpressure then reset mid-load
        clear_mon();
        d1 = $urandom;
        d2 = $urandom;
        send_word(hdr(8'hA5, 3, 10));
        send_word(d1);
        tick();
        tick();
        send_word(d2);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = $urandom;
        tick();
        chk("rst_outs", 64'({s_ready, stall_req, rf_we, rf_waddr, rf_wdata, busy, done, err}), 64'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        tick();
        tick();
        chk("rst_wr_cnt", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            chk("rst_wr0", 64'(obs_q[0]), 64'({5'd10, d1}));
            chk("rst_wr1", 64'(obs_q[1]), 64'({5'd11, d2}));
        end
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        chk("rst_hs_cnt", 64'(hs_cnt), 64'd3);
        $display("reset mid-load writes=%0d", obs_q.size());
        run_load(7, 3, 0, 1'b0, "post_rst");

        // Full file, data = index
        ack_dly = 2;
        run_load(0, 32, 0, 1'b1, "full");

        // Randomized loads with bubbles and random ack delays
        for (int r = 0; r < 6; r++) begin
            ack_dly = $urandom_range(ACK_TIMEOUT - 2, 0);
            run_load($urandom_range(31, 0), $urandom_range(32, 1), 3, 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
